// File: rtl/mult_pkg.sv
// Shared types and defaults for the shift-add multiplier control path.
// Imported by mult_control.
package mult_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      ADD,
      SHIFT,
      DONE
   } mult_state_t;

   localparam int N_BITS_DEF = 8;

endpackage

// File: rtl/mult_control.sv
// Sequencing FSM for the 8-bit signed shift-add multiplier.
// Drives register_unit loads/shift, the add/sub function and the X flop.
module mult_control
   import mult_pkg::*;
#(
   parameter int N_BITS = N_BITS_DEF
) (
   input  logic Clk,
   input  logic Reset,
   input  logic Run,
   input  logic ClearA_LoadB,
   input  logic M,
   output logic Clr_XA,
   output logic Ld_A,
   output logic Ld_X,
   output logic Ld_B,
   output logic Shift_En,
   output logic Fn,
   output logic Busy,
   output logic Done
);

   localparam int CNT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N_BITS - 1);

   mult_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      Clr_XA   = 1'b0;
      Ld_A     = 1'b0;
      Ld_B     = 1'b0;
      Shift_En = 1'b0;
      Fn       = 1'b0;
      Busy     = 1'b0;
      Done     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (Run) begin
               state_d = START;
            end else if (ClearA_LoadB) begin
               Ld_B   = 1'b1;
               Clr_XA = 1'b1;
            end
         end
         START: begin
            Busy    = 1'b1;
            Clr_XA  = 1'b1;
            cnt_d   = '0;
            state_d = ADD;
         end
         ADD: begin
            Busy    = 1'b1;
            Ld_A    = M;
            Fn      = (cnt_q == LAST);
            state_d = SHIFT;
         end
         SHIFT: begin
            Busy     = 1'b1;
            Shift_En = 1'b1;
            if (cnt_q == LAST) begin
               state_d = DONE;
            end else begin
               cnt_d   = cnt_q + 1'b1;
               state_d = ADD;
            end
         end
         DONE: begin
            Done = 1'b1;
            if (!Run) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      // Reset aborts at once: no strobe may escape in the reset cycle.
      if (Reset) begin
         Clr_XA   = 1'b0;
         Ld_A     = 1'b0;
         Ld_B     = 1'b0;
         Shift_En = 1'b0;
         Fn       = 1'b0;
         Busy     = 1'b0;
         Done     = 1'b0;
      end
   end

   assign Ld_X = Ld_A;

endmodule
